// File: rtl/fire4_5_expand3_ofm_writer_pkg.sv
// rtl/fire4_5_expand3_ofm_writer_pkg.sv - shared constants and FSM state type for the fire expand3 ofm writer
package fire_pkg;

  localparam int WIDTH     = 16;
  localparam int DSP_NO    = 128;
  localparam int WOUT      = 32;
  localparam int CH_TOTAL  = 256;
  localparam int CH_OFFSET = 128;
  localparam int NPIX      = WOUT * WOUT;
  localparam int AW        = $clog2(NPIX * CH_TOTAL);

  typedef enum logic [1:0] {IDLE, DRAIN, FEEDBACK} ofm_wr_state_t;

endpackage

// File: rtl/fire4_5_expand3_ofm_writer_shadow_bank.sv
// rtl/fire4_5_expand3_ofm_writer_shadow_bank.sv - load-enabled ofm register file with registered read mux
module ofm_shadow_bank #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 128,
  parameter int CW     = $clog2(DSP_NO)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [DSP_NO-1:0][WIDTH-1:0] ofm,
  input  logic                         rd_en,
  input  logic [CW-1:0]                rd_idx,
  output logic [WIDTH-1:0]             rd_data
);

  logic [DSP_NO-1:0][WIDTH-1:0] bank;

  always_ff @(posedge clk) begin
    if (load) bank <= ofm;
  end

  // A load presents word 0 straight from the input so the first write needs no extra cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (load) begin
      rd_data <= ofm[0];
    end else if (rd_en) begin
      rd_data <= bank[rd_idx];
    end
  end

endmodule

// File: rtl/fire4_5_expand3_ofm_writer.sv
// rtl/fire4_5_expand3_ofm_writer.sv - serialises expand3 ofm samples into the fire feature-map RAM
module fire4_5_expand3_ofm_writer #(
  parameter int WIDTH     = fire_pkg::WIDTH,
  parameter int DSP_NO    = fire_pkg::DSP_NO,
  parameter int WOUT      = fire_pkg::WOUT,
  parameter int CH_TOTAL  = fire_pkg::CH_TOTAL,
  parameter int CH_OFFSET = fire_pkg::CH_OFFSET,
  parameter int AW        = fire_pkg::AW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         layer_sel_i,
  input  logic                         sample_i,
  input  logic [DSP_NO-1:0][WIDTH-1:0] ofm_i,
  input  logic                         ram_gnt_i,
  output logic                         ram_we_o,
  output logic [AW-1:0]                ram_addr_o,
  output logic [WIDTH-1:0]             ram_data_o,
  output logic                         ram_feedback_4_o,
  output logic                         ram_feedback_5_o,
  output logic                         busy_o,
  output logic                         overflow_o
);

  import fire_pkg::ofm_wr_state_t;
  import fire_pkg::IDLE;
  import fire_pkg::DRAIN;
  import fire_pkg::FEEDBACK;

  localparam int NPIX = WOUT * WOUT;
  localparam int CW   = $clog2(DSP_NO);
  localparam int PW   = $clog2(NPIX);
  localparam logic [CW-1:0] CH_LAST  = CW'(DSP_NO - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);

  ofm_wr_state_t state;
  logic [CW-1:0] ch_cnt;
  logic [PW-1:0] pix_cnt, pix_nxt;
  logic [AW-1:0] base, base_nxt;
  logic          tag;
  logic          pend;
  logic          last_wr, layer_end, accept;

  assign last_wr   = (state == DRAIN) && ram_gnt_i && (ch_cnt == CH_LAST);
  assign layer_end = last_wr && (pix_cnt == PIX_LAST);
  // A pending bank parked through FEEDBACK blocks further samples until it drains.
  assign accept    = sample_i && ((state == IDLE) || (state == FEEDBACK && !pend) || last_wr);
  assign busy_o    = (state != IDLE);

  always_comb begin
    pix_nxt  = pix_cnt;
    base_nxt = base;
    if (layer_end) begin
      pix_nxt  = '0;
      base_nxt = '0;
    end else if (last_wr) begin
      pix_nxt  = pix_cnt + 1'b1;
      base_nxt = base + AW'(CH_TOTAL);
    end
  end

  ofm_shadow_bank #(
    .WIDTH  (WIDTH),
    .DSP_NO (DSP_NO),
    .CW     (CW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .ofm     (ofm_i),
    .rd_en   ((state == DRAIN) && ram_gnt_i && !last_wr),
    .rd_idx  (ch_cnt + 1'b1),
    .rd_data (ram_data_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      ch_cnt           <= '0;
      pix_cnt          <= '0;
      base             <= '0;
      tag              <= 1'b0;
      pend             <= 1'b0;
      ram_we_o         <= 1'b0;
      ram_addr_o       <= '0;
      ram_feedback_4_o <= 1'b0;
      ram_feedback_5_o <= 1'b0;
      overflow_o       <= 1'b0;
    end else begin
      ram_feedback_4_o <= 1'b0;
      ram_feedback_5_o <= 1'b0;
      pix_cnt          <= pix_nxt;
      base             <= base_nxt;
      if (sample_i && !accept) overflow_o <= 1'b1;
      if (accept && (layer_sel_i != tag) && (pix_nxt != '0)) overflow_o <= 1'b1;
      if (accept) tag <= layer_sel_i;

      case (state)
        IDLE, FEEDBACK: begin
          if (accept || pend) begin
            state      <= DRAIN;
            ch_cnt     <= '0;
            pend       <= 1'b0;
            ram_we_o   <= 1'b1;
            ram_addr_o <= base_nxt + AW'(CH_OFFSET);
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (ram_gnt_i && !last_wr) begin
            ch_cnt     <= ch_cnt + 1'b1;
            ram_addr_o <= ram_addr_o + 1'b1;
          end else if (layer_end) begin
            // The old tag is still visible here, so the pulse names the layer just finished.
            state            <= FEEDBACK;
            ch_cnt           <= '0;
            pend             <= accept;
            ram_we_o         <= 1'b0;
            ram_feedback_4_o <= !tag;
            ram_feedback_5_o <= tag;
          end else if (last_wr) begin
            ch_cnt <= '0;
            if (accept) begin
              ram_addr_o <= base_nxt + AW'(CH_OFFSET);
            end else begin
              state    <= IDLE;
              ram_we_o <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          ram_we_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fire4_5_expand3_ofm_writer.sv
// tb/tb_fire4_5_expand3_ofm_writer.sv - directed self-checking bench for the expand3 ofm writer
module tb_fire4_5_expand3_ofm_writer;

  // WOUT reduced to 8 (64 pixels per layer) to keep full-layer runs short.
  localparam int W = 16, N = 128, WO = 8, NPIX = WO * WO, CHT = 256, CHO = 128, AWT = 14;

  logic clk = 1'b0, rst = 1'b0, layer_sel = 1'b0, sample = 1'b0, gnt = 1'b1;
  logic [N-1:0][W-1:0] ofm = '0;
  logic           we, fb4, fb5, busy, ovf;
  logic [AWT-1:0] addr;
  logic [W-1:0]   data;

  int n_vec = 0, n_bad = 0;
  logic [AWT-1:0] q_addr[$];
  logic [W-1:0]   q_data[$];
  int fb4_cnt = 0, fb5_cnt = 0, stalls = 0, stall_err = 0;
  logic           prev_stall = 1'b0;
  logic [AWT-1:0] prev_addr = '0;
  logic [W-1:0]   prev_data = '0;
  int cyc;

  fire4_5_expand3_ofm_writer #(
    .WIDTH(W), .DSP_NO(N), .WOUT(WO), .CH_TOTAL(CHT), .CH_OFFSET(CHO), .AW(AWT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .layer_sel_i      (layer_sel),
    .sample_i         (sample),
    .ofm_i            (ofm),
    .ram_gnt_i        (gnt),
    .ram_we_o         (we),
    .ram_addr_o       (addr),
    .ram_data_o       (data),
    .ram_feedback_4_o (fb4),
    .ram_feedback_5_o (fb5),
    .busy_o           (busy),
    .overflow_o       (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall && (we !== 1'b1 || addr !== prev_addr || data !== prev_data)) stall_err++;
      prev_stall = we && !gnt;
      prev_addr  = addr;
      prev_data  = data;
      if (we && !gnt) stalls++;
      if (we && gnt) begin
        q_addr.push_back(addr);
        q_data.push_back(data);
      end
      if (fb4) fb4_cnt++;
      if (fb5) fb5_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int d0);
    for (int k = 0; k < N; k++) ofm[k] = W'(d0 + k);
  endtask

  task automatic strobe(input logic sel);
    layer_sel = sel;
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  task automatic wait_idle(output int n, input int budget);
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b0;
    sample = 1'b0;
    gnt = 1'b1;
    layer_sel = 1'b0;
    repeat (2) tick();
    q_addr.delete();
    q_data.delete();
    fb4_cnt = 0; fb5_cnt = 0; stalls = 0; stall_err = 0;
    rst = 1'b1;
    tick();
  endtask

  // Errors in one drained pixel: addresses pix*CHT+CHO+k, data d0+k.
  function automatic int run_errs(input int qi, input int pix, input int d0);
    int e = 0;
    for (int k = 0; k < N; k++) begin
      if (qi + k >= q_addr.size()) e++;
      else if (q_addr[qi+k] !== AWT'(pix * CHT + CHO + k) || q_data[qi+k] !== W'(d0 + k)) e++;
    end
    return e;
  endfunction

  initial begin
    int e;
    // 1: reset state and a single sample
    repeat (3) tick();
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_fb4", fb4, 0);
    check("rst_fb5", fb5, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b1;
    tick();
    fill(0);
    strobe(1'b0);
    check("t1_lat_we", we, 1);
    check("t1_first_addr", addr, 128);
    check("t1_first_data", data, 0);
    wait_idle(cyc, 400);
    check("t1_cycles", cyc, 128);
    check("t1_nwords", q_addr.size(), 128);
    check("t1_words", run_errs(0, 0, 0), 0);

    // 2: full fire4 layer, then a sample landing in FEEDBACK
    do_reset();
    for (int p = 0; p < NPIX; p++) begin
      fill(p * N);
      strobe(1'b0);
      if (p < NPIX - 1) wait_idle(cyc, 400);
    end
    cyc = 0;
    while (!fb4 && cyc < 300) begin
      tick();
      cyc++;
    end
    check("t2_fb4_seen", fb4, 1);
    check("t2_nwords", q_addr.size(), NPIX * N);
    e = 0;
    for (int p = 0; p < NPIX; p++) e += run_errs(p * N, p, p * N);
    check("t2_words", e, 0);
    if (q_addr.size() > 0) check("t2_last_addr", q_addr[q_addr.size()-1], (NPIX - 1) * CHT + 255);
    fill(7000);
    strobe(1'b0);
    check("t2_fbk_accept_we", we, 1);
    check("t2_fbk_accept_addr", addr, 128);
    check("t2_fb4_width", fb4, 0);
    wait_idle(cyc, 400);
    check("t2_fb4_cnt", fb4_cnt, 1);
    check("t2_fb5_cnt", fb5_cnt, 0);
    check("t2_fbk_words", run_errs(NPIX * N, 0, 7000), 0);
    check("t2_ovf", ovf, 0);

    // 3: grant toggling every cycle
    do_reset();
    fill(1000);
    strobe(1'b0);
    cyc = 0;
    while (busy && cyc < 600) begin
      gnt = cyc[0];
      tick();
      cyc++;
    end
    gnt = 1'b1;
    check("t3_cycles", cyc, 256);
    check("t3_stalls", stalls, 128);
    check("t3_stall_hold", stall_err, 0);
    check("t3_nwords", q_addr.size(), 128);
    check("t3_words", run_errs(0, 0, 1000), 0);

    // 4: sample mid-drain is dropped and flagged
    do_reset();
    fill(2000);
    strobe(1'b0);
    repeat (40) tick();
    fill(5000);
    strobe(1'b0);
    check("t4_ovf_set", ovf, 1);
    check("t4_drain_on", we, 1);
    wait_idle(cyc, 400);
    repeat (3) tick();
    check("t4_ovf_sticky", ovf, 1);
    check("t4_no_redrain", we, 0);
    check("t4_nwords", q_addr.size(), 128);
    check("t4_words", run_errs(0, 0, 2000), 0);

    // 5: sample coincident with the final granted write
    do_reset();
    fill(3000);
    strobe(1'b0);
    repeat (127) tick();
    fill(4000);
    strobe(1'b0);
    check("t5_b2b_we", we, 1);
    check("t5_b2b_addr", addr, 384);
    check("t5_b2b_data", data, 4000);
    check("t5_ovf", ovf, 0);
    wait_idle(cyc, 400);
    check("t5_cycles", cyc, 128);
    check("t5_nwords", q_addr.size(), 256);
    check("t5_words_a", run_errs(0, 0, 3000), 0);
    check("t5_words_b", run_errs(128, 1, 4000), 0);
    // layer select flips mid-layer: flagged, bank still drained
    fill(9000);
    strobe(1'b1);
    check("t5_tag_ovf", ovf, 1);
    wait_idle(cyc, 400);
    check("t5_tag_words", run_errs(256, 2, 9000), 0);

    // 6: reset mid-layer, then a fresh fire5 layer
    do_reset();
    for (int p = 0; p < 40; p++) begin
      fill(p);
      strobe(1'b0);
      wait_idle(cyc, 400);
    end
    fill(40);
    strobe(1'b0);
    repeat (60) tick();
    rst = 1'b0;
    #1;
    check("t6_rst_we", we, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_addr", addr, 0);
    check("t6_partial_words", q_addr.size(), 40 * N + 60);
    repeat (2) tick();
    check("t6_no_fb4", fb4_cnt, 0);
    do_reset();
    for (int p = 0; p < NPIX; p++) begin
      fill(p);
      strobe(1'b1);
      wait_idle(cyc, 400);
    end
    check("t6_restart", run_errs(0, 0, 0), 0);
    check("t6_nwords", q_addr.size(), NPIX * N);
    check("t6_fb5_cnt", fb5_cnt, 1);
    check("t6_fb4_cnt", fb4_cnt, 0);
    check("t6_ovf", ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
